// File: rtl/npc_lsu.sv
// Load/store unit between the EXU and a single-port 64-bit data memory.
// Builds dword-aligned accesses with byte lanes, extends load data, and rejects misaligned accesses.
module npc_lsu #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_unsigned,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_misalign,
  output logic              o_mem_valid,
  output logic              o_mem_wen,
  output logic [ADDR_W-1:0] o_mem_raddr,
  output logic [ADDR_W-1:0] o_mem_waddr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic [7:0]        o_mem_wmask,
  input  logic [DATA_W-1:0] i_mem_rdata
);

  localparam int CNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM,
    S_WAIT,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_wen;
  logic [2:0]          r_off;
  logic [1:0]          r_size;
  logic                r_unsigned;
  logic                r_resp_valid;
  logic [DATA_W-1:0]   r_resp_rdata;
  logic                r_resp_misalign;
  logic                r_mem_valid;
  logic                r_mem_wen;
  logic [ADDR_W-1:0]   r_mem_raddr;
  logic [ADDR_W-1:0]   r_mem_waddr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic [7:0]          r_mem_wmask;

  logic                w_accept;
  logic                w_misalign;
  logic [7:0]          w_size_mask;
  logic [7:0]          w_lane_mask;
  logic [ADDR_W-1:0]   w_dword_addr;
  logic [DATA_W-1:0]   w_lane_wdata;
  logic [DATA_W-1:0]   w_rdata_shifted;
  logic [DATA_W-1:0]   w_rdata_ext;

  function automatic logic [DATA_W-1:0] extend_load(
    input logic [DATA_W-1:0] raw,
    input logic [1:0]        size,
    input logic              uns
  );
    logic [DATA_W-1:0] res;
    case (size)
      2'd0:    res = {{(DATA_W-8){~uns & raw[7]}}, raw[7:0]};
      2'd1:    res = {{(DATA_W-16){~uns & raw[15]}}, raw[15:0]};
      2'd2:    res = {{(DATA_W-32){~uns & raw[31]}}, raw[31:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  assign o_req_ready     = (r_state == S_IDLE);
  assign o_resp_valid    = r_resp_valid;
  assign o_resp_rdata    = r_resp_rdata;
  assign o_resp_misalign = r_resp_misalign;
  assign o_mem_valid     = r_mem_valid;
  assign o_mem_wen       = r_mem_wen;
  assign o_mem_raddr     = r_mem_raddr;
  assign o_mem_waddr     = r_mem_waddr;
  assign o_mem_wdata     = r_mem_wdata;
  assign o_mem_wmask     = r_mem_wmask;

  assign w_accept     = i_req_valid & o_req_ready;
  assign w_dword_addr = {i_req_addr[ADDR_W-1:3], 3'b000};
  assign w_lane_wdata = i_req_wdata << {i_req_addr[2:0], 3'b000};
  assign w_lane_mask  = w_size_mask << i_req_addr[2:0];

  always_comb begin
    w_misalign  = 1'b0;
    w_size_mask = 8'h00;
    case (i_req_size)
      2'd0: begin
        w_misalign  = 1'b0;
        w_size_mask = 8'h01;
      end
      2'd1: begin
        w_misalign  = i_req_addr[0];
        w_size_mask = 8'h03;
      end
      2'd2: begin
        w_misalign  = |i_req_addr[1:0];
        w_size_mask = 8'h0F;
      end
      default: begin
        w_misalign  = |i_req_addr[2:0];
        w_size_mask = 8'hFF;
      end
    endcase
  end

  assign w_rdata_shifted = i_mem_rdata >> {r_off, 3'b000};
  assign w_rdata_ext     = extend_load(w_rdata_shifted, r_size, r_unsigned);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_next = w_misalign ? S_RESP : S_MEM;
        end
      end
      S_MEM: begin
        w_next = r_wen ? S_RESP : S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == CNT_W'(1)) begin
          w_next = S_RESP;
        end
      end
      S_RESP: begin
        if (i_resp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Memory-side address/data/mask hold their last values; only the strobe and write enable drop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt           <= '0;
      r_wen           <= 1'b0;
      r_off           <= 3'd0;
      r_size          <= 2'd0;
      r_unsigned      <= 1'b0;
      r_resp_valid    <= 1'b0;
      r_resp_rdata    <= '0;
      r_resp_misalign <= 1'b0;
      r_mem_valid     <= 1'b0;
      r_mem_wen       <= 1'b0;
      r_mem_raddr     <= '0;
      r_mem_waddr     <= '0;
      r_mem_wdata     <= '0;
      r_mem_wmask     <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_wen           <= i_req_wen;
            r_off           <= i_req_addr[2:0];
            r_size          <= i_req_size;
            r_unsigned      <= i_req_unsigned;
            r_resp_rdata    <= '0;
            r_resp_misalign <= w_misalign;
            if (w_misalign) begin
              r_resp_valid <= 1'b1;
            end else begin
              r_mem_valid <= 1'b1;
              r_mem_wen   <= i_req_wen;
              r_mem_raddr <= w_dword_addr;
              r_mem_waddr <= w_dword_addr;
              r_mem_wdata <= i_req_wen ? w_lane_wdata : '0;
              r_mem_wmask <= i_req_wen ? w_lane_mask : 8'h00;
            end
          end
        end
        S_MEM: begin
          r_mem_valid <= 1'b0;
          r_mem_wen   <= 1'b0;
          if (r_wen) begin
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= CNT_W'(MEM_LAT);
          end
        end
        S_WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            r_resp_rdata <= w_rdata_ext;
            r_resp_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (i_resp_ready) begin
            r_resp_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_lsu.sv
// Self-checking bench for npc_lsu: two instances (MEM_LAT 1 and 3), a behavioural memory,
// a transaction-level reference model and a per-cycle compare process.
module tb_npc_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        reqValid     [2];
  logic        reqReady     [2];
  logic        reqWen       [2];
  logic [31:0] reqAddr      [2];
  logic [63:0] reqWdata     [2];
  logic [1:0]  reqSize      [2];
  logic        reqUnsigned  [2];
  logic        respValid    [2];
  logic        respReady    [2];
  logic [63:0] respRdata    [2];
  logic        respMisalign [2];
  logic        memValid     [2];
  logic        memWen       [2];
  logic [31:0] memRaddr     [2];
  logic [31:0] memWaddr     [2];
  logic [63:0] memWdata     [2];
  logic [7:0]  memWmask     [2];
  logic [63:0] memRdata     [2];

  logic        expReady  [2];
  logic        expRvalid [2];
  logic [63:0] expRdata  [2];
  logic        expMis    [2];
  logic        expMvalid [2];
  logic        expMwen   [2];
  logic [31:0] expMaddr  [2];
  logic [63:0] expMwdata [2];
  logic [7:0]  expMwmask [2];
  logic        chkEn = 1'b0;

  logic [63:0] refm [2][16] = '{default: '0};

  int checks = 0;
  int errors = 0;

  npc_lsu #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(reqValid[0]), .o_req_ready(reqReady[0]), .i_req_wen(reqWen[0]),
    .i_req_addr(reqAddr[0]), .i_req_wdata(reqWdata[0]), .i_req_size(reqSize[0]),
    .i_req_unsigned(reqUnsigned[0]), .o_resp_valid(respValid[0]), .i_resp_ready(respReady[0]),
    .o_resp_rdata(respRdata[0]), .o_resp_misalign(respMisalign[0]), .o_mem_valid(memValid[0]),
    .o_mem_wen(memWen[0]), .o_mem_raddr(memRaddr[0]), .o_mem_waddr(memWaddr[0]),
    .o_mem_wdata(memWdata[0]), .o_mem_wmask(memWmask[0]), .i_mem_rdata(memRdata[0])
  );

  npc_lsu #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(reqValid[1]), .o_req_ready(reqReady[1]), .i_req_wen(reqWen[1]),
    .i_req_addr(reqAddr[1]), .i_req_wdata(reqWdata[1]), .i_req_size(reqSize[1]),
    .i_req_unsigned(reqUnsigned[1]), .o_resp_valid(respValid[1]), .i_resp_ready(respReady[1]),
    .o_resp_rdata(respRdata[1]), .o_resp_misalign(respMisalign[1]), .o_mem_valid(memValid[1]),
    .o_mem_wen(memWen[1]), .o_mem_raddr(memRaddr[1]), .o_mem_waddr(memWaddr[1]),
    .o_mem_wdata(memWdata[1]), .o_mem_wmask(memWmask[1]), .i_mem_rdata(memRdata[1])
  );

  // Memory: byte-masked writes, reads delayed by LAT edges with junk in between.
  for (genvar g = 0; g < 2; g++) begin : gMem
    localparam int LAT = (g == 0) ? 1 : 3;
    logic [63:0] phys [16] = '{default: '0};
    logic [63:0] pipe [3];
    assign memRdata[g] = pipe[LAT-1];
    always @(posedge clk) begin
      pipe[0] <= (memValid[g] && !memWen[g]) ? phys[memRaddr[g][6:3]] : {$urandom, $urandom};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      if (memValid[g] && memWen[g]) begin
        for (int b = 0; b < 8; b++) begin
          if (memWmask[g][b]) phys[memWaddr[g][6:3]][b*8 +: 8] <= memWdata[g][b*8 +: 8];
        end
      end
    end
  end

  task automatic checkOutput(input string nm, input int g, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s inst%0d: got 0x%h expected 0x%h", nm, g, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      for (int g = 0; g < 2; g++) begin
        checkOutput("req_ready", g, 64'(reqReady[g]), 64'(expReady[g]));
        checkOutput("resp_valid", g, 64'(respValid[g]), 64'(expRvalid[g]));
        checkOutput("mem_valid", g, 64'(memValid[g]), 64'(expMvalid[g]));
        if (expRvalid[g]) begin
          checkOutput("resp_rdata", g, respRdata[g], expRdata[g]);
          checkOutput("resp_misalign", g, 64'(respMisalign[g]), 64'(expMis[g]));
        end
        if (expMvalid[g]) begin
          checkOutput("mem_wen", g, 64'(memWen[g]), 64'(expMwen[g]));
          checkOutput("mem_raddr", g, 64'(memRaddr[g]), 64'(expMaddr[g]));
          checkOutput("mem_waddr", g, 64'(memWaddr[g]), 64'(expMaddr[g]));
          checkOutput("mem_wdata", g, memWdata[g], expMwdata[g]);
          checkOutput("mem_wmask", g, 64'(memWmask[g]), 64'(expMwmask[g]));
        end
      end
    end
  end

  task automatic checkResetOutputs(input int g);
    checkOutput("rst_resp_valid", g, 64'(respValid[g]), 64'd0);
    checkOutput("rst_resp_rdata", g, respRdata[g], 64'd0);
    checkOutput("rst_resp_misalign", g, 64'(respMisalign[g]), 64'd0);
    checkOutput("rst_mem_valid", g, 64'(memValid[g]), 64'd0);
    checkOutput("rst_mem_wen", g, 64'(memWen[g]), 64'd0);
    checkOutput("rst_mem_raddr", g, 64'(memRaddr[g]), 64'd0);
    checkOutput("rst_mem_waddr", g, 64'(memWaddr[g]), 64'd0);
    checkOutput("rst_mem_wdata", g, memWdata[g], 64'd0);
    checkOutput("rst_mem_wmask", g, 64'(memWmask[g]), 64'd0);
  endtask

  task automatic noise(input int g);
    reqValid[g]    = 1'($urandom);
    reqWen[g]      = 1'($urandom);
    reqAddr[g]     = $urandom;
    reqWdata[g]    = {$urandom, $urandom};
    reqSize[g]     = 2'($urandom);
    reqUnsigned[g] = 1'($urandom);
    respReady[g]   = 1'($urandom);
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on instance g; expectations derived from the access rules.
  task automatic applyStimulus(input int g, input bit wen, input logic [31:0] addr,
                               input logic [63:0] wdata, input logic [1:0] size, input bit uns,
                               input int stall, input bit pin, input logic [63:0] pinRdata,
                               input logic [7:0] pinMask, input logic [63:0] pinWdata);
    int lat, nb, off, idx;
    bit mis;
    logic [63:0] lowm, val, expData, shifted;
    logic [7:0] msk;
    lat = (g == 0) ? 1 : 3;
    nb  = 1 << size;
    mis = (addr % nb) != 0;
    off = int'(addr[2:0]);
    idx = int'(addr[6:3]);
    lowm = (nb == 8) ? '1 : ((64'd1 << (nb * 8)) - 64'd1);
    msk = 8'(((1 << nb) - 1) << off);
    shifted = wdata << (off * 8);
    expData = '0;
    if (!mis && !wen) begin
      val = (refm[g][idx] >> (off * 8)) & lowm;
      if (!uns && nb < 8 && val[nb*8-1]) val = val | ~lowm;
      expData = val;
    end
    if (!mis && wen) begin
      for (int b = 0; b < 8; b++) begin
        if (msk[b]) refm[g][idx][b*8 +: 8] = shifted[b*8 +: 8];
      end
    end

    reqValid[g] = 1'b1; reqWen[g] = wen; reqAddr[g] = addr; reqWdata[g] = wdata;
    reqSize[g] = size; reqUnsigned[g] = uns; respReady[g] = 1'($urandom);
    nextCycle();
    noise(g);
    expReady[g] = 1'b0;
    if (!mis) begin
      expMvalid[g] = 1'b1;
      expMwen[g]   = wen;
      expMaddr[g]  = {addr[31:3], 3'b000};
      expMwdata[g] = wen ? shifted : 64'd0;
      expMwmask[g] = wen ? msk : 8'h00;
      if (pin && wen) begin
        checkOutput("pin_wmask", g, 64'(memWmask[g]), 64'(pinMask));
        checkOutput("pin_wdata", g, memWdata[g], pinWdata);
      end
      nextCycle();
      noise(g);
      expMvalid[g] = 1'b0;
      if (!wen) begin
        for (int c = 0; c < lat; c++) begin
          nextCycle();
          noise(g);
        end
      end
    end
    expRvalid[g] = 1'b1;
    expRdata[g]  = expData;
    expMis[g]    = mis;
    if (pin) checkOutput("pin_rdata", g, respRdata[g], pinRdata);
    for (int s = 0; s < stall; s++) begin
      respReady[g] = 1'b0;
      nextCycle();
      noise(g);
    end
    respReady[g] = 1'b1;
    nextCycle();
    expRvalid[g] = 1'b0;
    expReady[g]  = 1'b1;
    reqValid[g]  = 1'b0;
    respReady[g] = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] addr;
    logic [1:0]  size;
    for (int g = 0; g < 2; g++) begin
      reqValid[g] = 1'b0; reqWen[g] = 1'b0; reqAddr[g] = '0; reqWdata[g] = '0;
      reqSize[g] = '0; reqUnsigned[g] = 1'b0; respReady[g] = 1'b0;
      expReady[g] = 1'b1; expRvalid[g] = 1'b0; expRdata[g] = '0; expMis[g] = 1'b0;
      expMvalid[g] = 1'b0; expMwen[g] = 1'b0; expMaddr[g] = '0; expMwdata[g] = '0;
      expMwmask[g] = '0;
    end
    #1 rst_n = 1'b0;
    #1;
    checkResetOutputs(0);
    checkResetOutputs(1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1 chkEn = 1'b1;
    nextCycle();

    $display("[TB] directed accesses, MEM_LAT=1");
    applyStimulus(0, 1, 32'h80000004, 64'hDEADBEEF, 2'd2, 0, 0, 1, 64'd0, 8'hF0,
                  64'hDEADBEEF00000000);
    applyStimulus(0, 1, 32'h80000000, 64'h0000000080000000, 2'd3, 0, 0, 1, 64'd0, 8'hFF,
                  64'h0000000080000000);
    applyStimulus(0, 0, 32'h80000003, 64'd0, 2'd0, 0, 0, 1, 64'hFFFFFFFFFFFFFF80, 8'h00, 64'd0);
    applyStimulus(0, 0, 32'h80000003, 64'd0, 2'd0, 1, 0, 1, 64'h0000000000000080, 8'h00, 64'd0);
    applyStimulus(0, 0, 32'h80000001, 64'd0, 2'd1, 0, 0, 1, 64'd0, 8'h00, 64'd0);
    applyStimulus(0, 0, 32'h80000000, 64'd0, 2'd3, 1, 5, 1, 64'h0000000080000000, 8'h00, 64'd0);

    $display("[TB] directed accesses, MEM_LAT=3");
    applyStimulus(1, 1, 32'h80000000, 64'h89ABCDEF00000000, 2'd3, 0, 0, 0, 64'd0, 8'h00, 64'd0);
    applyStimulus(1, 0, 32'h80000004, 64'd0, 2'd2, 1, 0, 1, 64'h0000000089ABCDEF, 8'h00, 64'd0);
    applyStimulus(1, 0, 32'h80000004, 64'd0, 2'd2, 0, 2, 1, 64'hFFFFFFFF89ABCDEF, 8'h00, 64'd0);

    $display("[TB] reset during WAIT");
    reqValid[1] = 1'b1; reqWen[1] = 1'b0; reqAddr[1] = 32'h80000000;
    reqSize[1] = 2'd3; reqUnsigned[1] = 1'b0;
    nextCycle();
    reqValid[1] = 1'b0; expReady[1] = 1'b0; expMvalid[1] = 1'b1; expMwen[1] = 1'b0;
    expMaddr[1] = 32'h80000000; expMwdata[1] = '0; expMwmask[1] = '0;
    nextCycle();
    expMvalid[1] = 1'b0;
    nextCycle();
    chkEn = 1'b0;
    rst_n = 1'b0;
    #1;
    checkResetOutputs(1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    expReady[1] = 1'b1;
    chkEn = 1'b1;
    repeat (8) @(posedge clk);
    #1;

    $display("[TB] randomized accesses");
    for (int g = 0; g < 2; g++) begin
      for (int n = 0; n < 60; n++) begin
        size = 2'($urandom);
        addr = 32'h80000000 | ($urandom % 128);
        if ($urandom % 4 != 0) addr = addr & ~((32'd1 << size) - 32'd1);
        applyStimulus(g, 1'($urandom), addr, {$urandom, $urandom}, size, 1'($urandom),
                      int'($urandom % 4), 0, 64'd0, 8'h00, 64'd0);
        repeat ($urandom % 3) nextCycle();
      end
    end
    repeat (2) nextCycle();
    chkEn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
